// File: rtl/bin16s_to_dec4_sgn_pkg.sv
// Shared constants for the signed binary to 4-digit BCD converter.
package bin16s_to_dec4_sgn_pkg;

    // FSM encodings, kept as plain constants so the encoding stays stable.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Datapath geometry: 16 magnitude bits and 5 BCD digits (max 32768).
    localparam int unsigned N_BITS = 16;
    localparam int unsigned N_BCD  = 5;
    localparam int unsigned BCD_W  = 4 * N_BCD;
    localparam int unsigned SR_W   = BCD_W + N_BITS;

    // Largest 4-digit value, also the saturated display pattern.
    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Double-dabble nibble correction constants.
    localparam logic [3:0] DD_THRESH = 4'd5;
    localparam logic [3:0] DD_ADJ    = 4'd3;

    // Two's-complement magnitude truncated to 16 bits; 0x8000 maps to 32768.
    function automatic logic [15:0] abs16(input logic [15:0] x);
        return x[15] ? ((~x) + 16'd1) : x;
    endfunction

endpackage

// File: rtl/bin16s_to_dec4_sgn_dd_add3.sv
// Combinational double-dabble corrector for one BCD digit.
module dd_add3
    import bin16s_to_dec4_sgn_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add 3 to a digit of 5 or more so the following left shift carries correctly.
    always_comb begin
        dout = din;
        if (din >= DD_THRESH) begin
            dout = din + DD_ADJ;
        end
    end

endmodule

// File: rtl/bin16s_to_dec4_sgn.sv
// Sequential signed 16-bit binary to 4-digit BCD converter with sign and
// overflow flags. One magnitude bit is processed per clock.
module bin16s_to_dec4_sgn
    import bin16s_to_dec4_sgn_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic [15:0] BIN,
    output logic [15:0] DEC,
    output logic        NEG,
    output logic        OVF,
    output logic        busy,
    output logic        done
);

    logic [1:0]       state;
    logic [4:0]       cnt;
    logic [SR_W-1:0]  sr;       // {bcd[19:0], mag[15:0]}
    logic             neg_r;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_fin;
    logic             ovf_c;
    logic             neg_c;
    logic [15:0]      dec_c;

    // One corrector per BCD digit of the accumulator.
    for (genvar g = 0; g < N_BCD; g++) begin : g_add3
        dd_add3 u_add3 (
            .din  (sr[N_BITS + 4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign bcd_fin = sr[SR_W-1:N_BITS];
    assign busy    = (state != ST_IDLE);

    // Result formatting: overflow only from the fifth digit, no negative zero.
    always_comb begin
        ovf_c = (bcd_fin[19:16] != 4'd0) || (bcd_fin[15:0] > BCD_MAX);
        neg_c = neg_r && (bcd_fin != '0);
        dec_c = bcd_fin[15:0];
        if (ovf_c && SATURATE) begin
            dec_c = BCD_MAX;
        end
    end

    // Control FSM and bit counter: IDLE -> 16 x SHIFT -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (st) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(N_BITS - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: capture magnitude and sign on start, then correct-and-shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            neg_r <= 1'b0;
        end else begin
            if (state == ST_IDLE && st) begin
                sr    <= {{BCD_W{1'b0}}, abs16(BIN)};
                neg_r <= BIN[15];
            end else if (state == ST_SHIFT) begin
                sr <= {bcd_adj, sr[N_BITS-1:0]} << 1;
            end
        end
    end

    // Output registers load only in DONE and hold between conversions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DEC  <= '0;
            NEG  <= 1'b0;
            OVF  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_DONE) begin
                DEC  <= dec_c;
                NEG  <= neg_c;
                OVF  <= ovf_c;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin16s_to_dec4_sgn.sv
// Scoreboard bench for bin16s_to_dec4_sgn, saturating and wrapping variants.
module tb_bin16s_to_dec4_sgn;

    logic        clk;
    logic        rst;
    logic        st;
    logic [15:0] BIN;
    logic [15:0] DEC,  DEC_ns;
    logic        NEG,  NEG_ns;
    logic        OVF,  OVF_ns;
    logic        busy, busy_ns;
    logic        done, done_ns;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] dec;
        logic [15:0] dec_raw;
        logic        neg;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          n_push = 0;
    logic [15:0] last_dec = 16'h0000;

    bin16s_to_dec4_sgn dut (
        .clk (clk), .rst (rst), .st (st), .BIN (BIN),
        .DEC (DEC), .NEG (NEG), .OVF (OVF), .busy (busy), .done (done)
    );

    bin16s_to_dec4_sgn #(.SATURATE(1'b0)) dut_ns (
        .clk (clk), .rst (rst), .st (st), .BIN (BIN),
        .DEC (DEC_ns), .NEG (NEG_ns), .OVF (OVF_ns), .busy (busy_ns), .done (done_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model working on integers and decimal digits.
    function automatic exp_t model(input logic [15:0] b, input int acc);
        exp_t r;
        int   v;
        int   m;
        int   low;
        v = int'($signed(b));
        m = (v < 0) ? -v : v;
        low = m % 10000;
        r.bin     = b;
        r.ovf     = (m > 9999);
        r.neg     = (v < 0);
        r.dec_raw = {4'(low / 1000), 4'((low / 100) % 10), 4'((low / 10) % 10), 4'(low % 10)};
        r.dec     = r.ovf ? 16'h9999 : r.dec_raw;
        r.acc     = acc;
        return r;
    endfunction

    // Monitor: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && (done || done_ns)) begin
            n_done++;
            if (sb.size() == 0) begin
                check_eq("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("latency",  cyc,            e.acc + 17);
                check_eq("done_ns",  {31'b0, done_ns}, 32'd1);
                check_eq("busy_end", {31'b0, busy},    32'd0);
                check_eq("DEC",      {16'b0, DEC},     {16'b0, e.dec});
                check_eq("NEG",      {31'b0, NEG},     {31'b0, e.neg});
                check_eq("OVF",      {31'b0, OVF},     {31'b0, e.ovf});
                check_eq("DEC_ns",   {16'b0, DEC_ns},  {16'b0, e.dec_raw});
                check_eq("NEG_ns",   {31'b0, NEG_ns},  {31'b0, e.neg});
                check_eq("OVF_ns",   {31'b0, OVF_ns},  {31'b0, e.ovf});
                last_dec = e.dec;
            end
        end
    end

    task automatic convert(input logic [15:0] b);
        @(negedge clk);
        check_eq("idle_before_st", {31'b0, busy}, 32'd0);
        BIN = b;
        st  = 1'b1;
        sb.push_back(model(b, cyc + 1));
        n_push++;
        @(posedge clk);
        #1 st = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("idle_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic run(input logic [15:0] b);
        convert(b);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        st  = 1'b0;
        BIN = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_DEC",  {16'b0, DEC},  32'd0);
        check_eq("rst_NEG",  {31'b0, NEG},  32'd0);
        check_eq("rst_OVF",  {31'b0, OVF},  32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(16'd1234);
        run(16'hFFFF);
        run(16'h0000);
        run(16'h8000);
        run(16'd10000);
        run(16'd9999);
        run(16'h7FFF);
        run(16'hD8F1);   // -9999
        run(16'hD8F0);   // -10000
        for (int i = 0; i < 8; i++) begin
            run(16'($urandom));
        end

        // Hammer st with a changing BIN while busy; only the first capture counts.
        convert(16'd4321);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            check_eq("busy_during", {31'b0, busy}, 32'd1);
            check_eq("hold_DEC",    {16'b0, DEC},  {16'b0, last_dec});
            BIN = 16'($urandom);
            st  = 1'b1;
        end
        // Re-accepted on the first edge after busy falls.
        convert(16'hFF06);  // -250
        wait_idle();

        // Abort mid-conversion after the 8th shift.
        @(negedge clk);
        BIN = 16'd1234;
        st  = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("abort_DEC",  {16'b0, DEC},  32'd0);
        check_eq("abort_NEG",  {31'b0, NEG},  32'd0);
        check_eq("abort_OVF",  {31'b0, OVF},  32'd0);
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        check_eq("abort_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check_eq("done_count_abort", n_done, n_push);

        run(16'hFF06);
        check_eq("done_count", n_done, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
